uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte requesters.
// It latches one byte per frame, strobes tx_start and supervises the transmitter's busy/done handshake.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*8-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               err,
  output logic [15:0]        frame_count,
  output logic [1:0]         state
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // The timer holds the count of ready-high WAIT_BUSY cycles already seen.
  // One more such cycle at this value means the timeout is reached.
  localparam logic [2:0] TIMER_LAST = 3'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [2:0]       timer_q, timer_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             err_q, err_d;
  logic [15:0]      frame_count_q, frame_count_d;

  logic [N_REQ-1:0] eligible;
  logic             pick_valid;
  logic [PW-1:0]    pick_idx;
  logic [PW-1:0]    ptr_after;
  int               idx;

  // A requester being acked this cycle still holds req, so it is masked out.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    eligible   = req & ~ack_q;
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!pick_valid && eligible[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'(idx);
      end
    end
  end

  assign ptr_after = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    win_d         = win_q;
    timer_d       = '0;
    tx_data_d     = tx_data_q;
    grant_d       = grant_q;
    ack_d         = '0;
    err_d         = 1'b0;
    frame_count_d = frame_count_q;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (tx_ready && pick_valid) begin
          state_d   = S_ISSUE;
          win_d     = pick_idx;
          tx_data_d = req_data[8*int'(pick_idx) +: 8];
          grant_d   = N_REQ'(1) << pick_idx;
        end
      end
      S_ISSUE: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!tx_ready) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q == TIMER_LAST) begin
          // Transmitter never went busy: abandon this frame without an ack.
          state_d = S_IDLE;
          err_d   = 1'b1;
          grant_d = '0;
          ptr_d   = ptr_after;
        end else begin
          timer_d = timer_q + 3'd1;
        end
      end
      S_WAIT_DONE: begin
        if (tx_ready) begin
          state_d       = S_IDLE;
          ack_d         = N_REQ'(1) << win_q;
          grant_d       = '0;
          frame_count_d = frame_count_q + 16'd1;
          ptr_d         = ptr_after;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      win_q         <= '0;
      timer_q       <= '0;
      tx_data_q     <= '0;
      grant_q       <= '0;
      ack_q         <= '0;
      err_q         <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      win_q         <= win_d;
      timer_q       <= timer_d;
      tx_data_q     <= tx_data_d;
      grant_q       <= grant_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign tx_start    = (state_q == S_ISSUE);
  assign tx_data     = tx_data_q;
  assign grant       = grant_q;
  assign ack         = ack_q;
  assign err         = err_q;
  assign frame_count = frame_count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int BT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [3:0]  grant;
  logic        err;
  logic [15:0] frame_count;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(BT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .grant       (grant),
    .err         (err),
    .frame_count (frame_count),
    .state       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        ready;
    logic [3:0]  e_grant;
    logic        e_start;
    logic [7:0]  e_data;
    logic [3:0]  e_ack;
    logic        e_err;
    logic [15:0] e_fc;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic reset_dut();
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns at the ISSUE cycle of the next frame, whose owner must be 'win'.
  task automatic wait_grant(input int win, input logic [7:0] d, input string tag);
    int n;
    n = 0;
    while (grant == 4'b0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".grant"}, 32'(grant), 32'(oh(win)));
    check({tag, ".tx_start"}, 32'(tx_start), 32'd1);
    check({tag, ".tx_data"}, 32'(tx_data), 32'(d));
  endtask

  // From the ISSUE cycle: busy for two cycles, then ready; returns at the ack cycle.
  task automatic finish_frame(input int win, input logic [15:0] fc, input string tag);
    @(negedge clk);
    tx_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    check({tag, ".ack"}, 32'(ack), 32'(oh(win)));
    check({tag, ".grant_clr"}, 32'(grant), 32'd0);
    check({tag, ".fc"}, 32'(frame_count), 32'(fc));
  endtask

  // Reference model state for the randomized run.
  logic [3:0]  outst;
  logic [7:0]  rdata [4];
  int          ptr_m, win_m, g_m, end_m, d_m, l_m;
  bit          active_m, tmo_m, found;
  logic [7:0]  fdata_m, txd_m;
  logic [15:0] fc_m;
  logic [3:0]  ack_m, e_grant;
  logic        err_m, rdy;
  logic [1:0]  e_state;

  initial begin
    vecs[0]  = '{4'b0001, 32'h0000_00A5, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 16'd0, 2'd0};
    vecs[1]  = '{4'b0001, 32'h0000_00A5, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 16'd0, 2'd0};
    vecs[2]  = '{4'b0001, 32'h0000_003C, 1'b1, 4'b0001, 1'b1, 8'hA5, 4'b0000, 1'b0, 16'd0, 2'd1};
    vecs[3]  = '{4'b0001, 32'h0000_003C, 1'b0, 4'b0001, 1'b0, 8'hA5, 4'b0000, 1'b0, 16'd0, 2'd2};
    vecs[4]  = '{4'b0001, 32'h0000_003C, 1'b0, 4'b0001, 1'b0, 8'hA5, 4'b0000, 1'b0, 16'd0, 2'd3};
    vecs[5]  = '{4'b0001, 32'h0000_003C, 1'b1, 4'b0001, 1'b0, 8'hA5, 4'b0000, 1'b0, 16'd0, 2'd3};
    vecs[6]  = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 4'b0001, 1'b0, 16'd1, 2'd0};
    vecs[7]  = '{4'b0110, 32'h0088_7700, 1'b1, 4'b0000, 1'b0, 8'hA5, 4'b0000, 1'b0, 16'd1, 2'd0};
    vecs[8]  = '{4'b0110, 32'h0088_7700, 1'b1, 4'b0010, 1'b1, 8'h77, 4'b0000, 1'b0, 16'd1, 2'd1};
    vecs[9]  = '{4'b0110, 32'h0088_7700, 1'b1, 4'b0010, 1'b0, 8'h77, 4'b0000, 1'b0, 16'd1, 2'd2};
    vecs[10] = '{4'b0110, 32'h0088_7700, 1'b1, 4'b0010, 1'b0, 8'h77, 4'b0000, 1'b0, 16'd1, 2'd2};
    vecs[11] = '{4'b0110, 32'h0088_7700, 1'b1, 4'b0010, 1'b0, 8'h77, 4'b0000, 1'b0, 16'd1, 2'd2};
    vecs[12] = '{4'b0110, 32'h0088_7700, 1'b1, 4'b0010, 1'b0, 8'h77, 4'b0000, 1'b0, 16'd1, 2'd2};
    vecs[13] = '{4'b0110, 32'h0088_7700, 1'b1, 4'b0000, 1'b0, 8'h77, 4'b0000, 1'b1, 16'd1, 2'd0};
    vecs[14] = '{4'b0110, 32'h0088_7700, 1'b1, 4'b0100, 1'b1, 8'h88, 4'b0000, 1'b0, 16'd1, 2'd1};
    vecs[15] = '{4'b0110, 32'h0088_7700, 1'b0, 4'b0100, 1'b0, 8'h88, 4'b0000, 1'b0, 16'd1, 2'd2};
    vecs[16] = '{4'b0110, 32'h0088_7700, 1'b1, 4'b0100, 1'b0, 8'h88, 4'b0000, 1'b0, 16'd1, 2'd3};
    vecs[17] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h88, 4'b0100, 1'b0, 16'd2, 2'd0};
    vecs[18] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h88, 4'b0000, 1'b0, 16'd2, 2'd0};

    // Reset values while rst is held.
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    tx_ready = 1'b1;
    @(negedge clk);
    check("rst.grant", 32'(grant), 32'd0);
    check("rst.ack", 32'(ack), 32'd0);
    check("rst.tx_start", 32'(tx_start), 32'd0);
    check("rst.tx_data", 32'(tx_data), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.fc", 32'(frame_count), 32'd0);
    check("rst.state", 32'(state), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single frame, ready-low hold-off, ignored data change, then a busy timeout.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d.grant", i), 32'(grant), 32'(vecs[i].e_grant));
      check($sformatf("vec%0d.tx_start", i), 32'(tx_start), 32'(vecs[i].e_start));
      check($sformatf("vec%0d.tx_data", i), 32'(tx_data), 32'(vecs[i].e_data));
      check($sformatf("vec%0d.ack", i), 32'(ack), 32'(vecs[i].e_ack));
      check($sformatf("vec%0d.err", i), 32'(err), 32'(vecs[i].e_err));
      check($sformatf("vec%0d.fc", i), 32'(frame_count), 32'(vecs[i].e_fc));
      check($sformatf("vec%0d.state", i), 32'(state), 32'(vecs[i].e_state));
      req      = vecs[i].req;
      req_data = vecs[i].data;
      tx_ready = vecs[i].ready;
    end

    // All four requesting and held: strict rotation 0,1,2,3,0.
    reset_dut();
    req      = 4'hF;
    req_data = 32'h4332_2110;
    for (int k = 0; k < 5; k++) begin
      wait_grant(k % 4, req_data[8*(k%4) +: 8], $sformatf("rr%0d", k));
      finish_frame(k % 4, 16'(k + 1), $sformatf("rr%0d", k));
      @(negedge clk);
      check($sformatf("rr%0d.ack_once", k), 32'(ack), 32'd0);
    end

    // Requester 2 arrives mid-frame and wins right after ack[0].
    reset_dut();
    req      = 4'b0001;
    req_data = 32'h0000_0011;
    wait_grant(0, 8'h11, "pend_a");
    req      = 4'b0101;
    req_data = 32'h00C7_0011;
    finish_frame(0, 16'd1, "pend_a");
    req = 4'b0100;
    @(negedge clk);
    check("pend_b.grant", 32'(grant), 32'b0100);
    check("pend_b.tx_data", 32'(tx_data), 32'hC7);
    finish_frame(2, 16'd2, "pend_b");
    req = '0;

    // Reset during WAIT_DONE drops the frame; pointer returns to 0.
    reset_dut();
    req      = 4'b0010;
    req_data = 32'h0000_5500;
    wait_grant(1, 8'h55, "mrst_a");
    finish_frame(1, 16'd1, "mrst_a");
    req      = 4'b0100;
    req_data = 32'h0066_0000;
    wait_grant(2, 8'h66, "mrst_b");
    @(negedge clk);
    tx_ready = 1'b0;
    @(negedge clk);
    check("mrst.in_wait_done", 32'(state), 32'd3);
    rst = 1'b1;
    #1;
    check("mrst.grant", 32'(grant), 32'd0);
    check("mrst.tx_start", 32'(tx_start), 32'd0);
    check("mrst.tx_data", 32'(tx_data), 32'd0);
    check("mrst.ack", 32'(ack), 32'd0);
    check("mrst.err", 32'(err), 32'd0);
    check("mrst.fc", 32'(frame_count), 32'd0);
    check("mrst.state", 32'(state), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    tx_ready = 1'b1;
    req      = 4'hF;
    req_data = 32'h4433_2211;
    @(negedge clk);
    check("mrst.no_ack", 32'(ack), 32'd0);
    wait_grant(0, 8'h11, "mrst_c");
    finish_frame(0, 16'd1, "mrst_c");
    req = '0;

    // frame_count wraps from 0xFFFF.
    @(negedge clk);
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    check("wrap.pre", 32'(frame_count), 32'hFFFF);
    req      = 4'b0010;
    req_data = 32'h0000_9900;
    wait_grant(1, 8'h99, "wrap");
    finish_frame(1, 16'h0000, "wrap");
    req = '0;

    // Randomized traffic against the transaction-level model.
    reset_dut();
    outst    = '0;
    ptr_m    = 0;
    active_m = 1'b0;
    tmo_m    = 1'b0;
    win_m    = 0;
    g_m      = 0;
    end_m    = 0;
    d_m      = 0;
    l_m      = 1;
    fdata_m  = '0;
    txd_m    = '0;
    fc_m     = '0;
    for (int i = 0; i < 4; i++) rdata[i] = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ack_m = '0;
      err_m = 1'b0;
      if (active_m && c == end_m) begin
        active_m = 1'b0;
        if (tmo_m) begin
          err_m = 1'b1;
        end else begin
          ack_m        = oh(win_m);
          fc_m         = fc_m + 16'd1;
          outst[win_m] = 1'b0;
        end
      end
      if (active_m && c == g_m) txd_m = fdata_m;
      e_grant = (active_m && c >= g_m) ? oh(win_m) : 4'b0;
      if (!active_m)                       e_state = 2'd0;
      else if (c == g_m)                   e_state = 2'd1;
      else if (tmo_m || c <= g_m + 1 + d_m) e_state = 2'd2;
      else                                 e_state = 2'd3;
      check($sformatf("rnd%0d.grant", c), 32'(grant), 32'(e_grant));
      check($sformatf("rnd%0d.tx_start", c), 32'(tx_start), 32'(active_m && c == g_m));
      check($sformatf("rnd%0d.tx_data", c), 32'(tx_data), 32'(txd_m));
      check($sformatf("rnd%0d.ack", c), 32'(ack), 32'(ack_m));
      check($sformatf("rnd%0d.err", c), 32'(err), 32'(err_m));
      check($sformatf("rnd%0d.fc", c), 32'(frame_count), 32'(fc_m));
      check($sformatf("rnd%0d.state", c), 32'(state), 32'(e_state));

      if (active_m) rdy = !(!tmo_m && c >= g_m + 1 + d_m && c <= g_m + d_m + l_m);
      else          rdy = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < 4; i++) begin
        if (!outst[i] && $urandom_range(0, 3) == 0) begin
          outst[i] = 1'b1;
          rdata[i] = 8'($urandom);
        end
      end
      req      = outst;
      req_data = {rdata[3], rdata[2], rdata[1], rdata[0]};
      tx_ready = rdy;

      if (!active_m && rdy && (outst & ~ack_m) != 4'b0) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!found && (outst[(ptr_m + k) % 4] && !ack_m[(ptr_m + k) % 4])) begin
            found = 1'b1;
            win_m = (ptr_m + k) % 4;
          end
        end
        fdata_m  = rdata[win_m];
        g_m      = c + 1;
        d_m      = $urandom_range(0, BT);
        tmo_m    = (d_m == BT);
        l_m      = $urandom_range(1, 4);
        end_m    = tmo_m ? (g_m + 1 + BT) : (g_m + 2 + d_m + l_m);
        ptr_m    = (win_m + 1) % 4;
        active_m = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
